// File: rtl/instr_encoder.sv
// RV32I instruction encoder and program streamer: packs field sets into 32-bit words
// and streams them with byte addresses. Optional legality checking under ENC_CHECK_EN.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        restart,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_err
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    state_t      state_r;
    logic        alive_r;
    logic [31:0] addr_cnt_r;
    logic [31:0] out_instr_r;
    logic [31:0] out_addr_r;
    logic        out_err_r;

    logic        accept_s;
    logic        drain_s;
    logic [31:0] enc_s;
    logic [31:0] word_s;
    logic        err_s;

    function automatic logic [31:0] encode(
        input logic [2:0]  f,
        input logic [6:0]  op,
        input logic [4:0]  d,
        input logic [2:0]  f3,
        input logic [4:0]  s1,
        input logic [4:0]  s2,
        input logic [6:0]  f7,
        input logic [31:0] im
    );
        logic [31:0] w;
        case (f)
            3'd0:    w = {f7, s2, s1, f3, d, op};
            3'd1:    w = {im[11:0], s1, f3, d, op};
            3'd2:    w = {im[11:5], s2, s1, f3, im[4:0], op};
            3'd3:    w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
            3'd4:    w = {im[31:12], d, op};
            3'd5:    w = {im[20], im[10:1], im[11], im[19:12], d, op};
            default: w = {25'b0, op};
        endcase
        return w;
    endfunction

`ifdef ENC_CHECK_EN
    // A value fits a signed field when all bits above the field's sign bit match it.
    function automatic logic illegal(
        input logic [2:0]  f,
        input logic [6:0]  op,
        input logic [31:0] im
    );
        logic bad;
        case (f)
            3'd0:    bad = 1'b0;
            3'd1,
            3'd2:    bad = !((&im[31:11]) || (~|im[31:11]));
            3'd3:    bad = !((&im[31:12]) || (~|im[31:12])) || im[0];
            3'd4:    bad = |im[11:0];
            3'd5:    bad = !((&im[31:20]) || (~|im[31:20])) || im[0];
            default: bad = 1'b1;
        endcase
        if (op[1:0] != 2'b11) begin
            bad = 1'b1;
        end else begin
            bad = bad;
        end
        return bad;
    endfunction

    // Encoded word with illegal field sets replaced by a NOP.
    always_comb begin
        enc_s  = encode(fmt, opcode, rd, funct3, rs1, rs2, funct7, imm);
        err_s  = illegal(fmt, opcode, imm);
        if (err_s) begin
            word_s = NOP_INSTR;
        end else begin
            word_s = enc_s;
        end
    end
`else
    // Encoded word, no legality checking.
    always_comb begin
        enc_s  = encode(fmt, opcode, rd, funct3, rs1, rs2, funct7, imm);
        err_s  = 1'b0;
        word_s = enc_s;
    end
`endif

    assign in_ready  = alive_r && !restart && ((state_r == ST_EMPTY) || out_ready);
    assign accept_s  = in_valid && in_ready;
    assign drain_s   = (state_r == ST_FULL) && out_ready;

    assign out_valid = (state_r == ST_FULL);
    assign out_instr = out_instr_r;
    assign out_addr  = out_addr_r;
    assign out_err   = out_err_r;

    // Output register state machine and address counter; restart overrides handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            alive_r     <= 1'b0;
            addr_cnt_r  <= BASE_ADDR;
            out_instr_r <= 32'h0000_0000;
            out_addr_r  <= 32'h0000_0000;
            out_err_r   <= 1'b0;
        end else if (restart) begin
            state_r     <= ST_EMPTY;
            alive_r     <= 1'b1;
            addr_cnt_r  <= BASE_ADDR;
            out_instr_r <= 32'h0000_0000;
            out_addr_r  <= 32'h0000_0000;
            out_err_r   <= 1'b0;
        end else begin
            alive_r <= 1'b1;
            if (accept_s) begin
                state_r     <= ST_FULL;
                out_instr_r <= word_s;
                out_addr_r  <= addr_cnt_r;
                out_err_r   <= err_s;
                addr_cnt_r  <= addr_cnt_r + 32'd4;
            end else if (drain_s) begin
                state_r <= ST_EMPTY;
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: scoreboard of expected words/addresses checked on
// every output handshake, plus direct checks of reset, backpressure, restart and wrap.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        restart;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;

    logic        restart_w;
    logic        in_valid_w;
    logic        in_ready_w;
    logic        out_valid_w;
    logic        out_ready_w;
    logic [31:0] out_instr_w;
    logic [31:0] out_addr_w;
    logic        out_err_w;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    exp_t        dropped;
    logic [31:0] exp_addr;
    int          w;

`ifdef ENC_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    always #5 clk = ~clk;

    instr_encoder #(.BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err)
    );

    instr_encoder #(.BASE_ADDR(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst_n(rst_n), .restart(restart_w),
        .in_valid(in_valid_w), .in_ready(in_ready_w),
        .fmt(fmt), .opcode(opcode), .rd(rd), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .funct7(funct7), .imm(imm),
        .out_valid(out_valid_w), .out_ready(out_ready_w),
        .out_instr(out_instr_w), .out_addr(out_addr_w), .out_err(out_err_w)
    );

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one field set, wait (bounded) for acceptance, record expectation.
    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                        input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [6:0] f7, input logic [31:0] im,
                        input logic [31:0] einstr, input logic eerr, output int waits);
        fmt = f; opcode = op; rd = d; funct3 = f3;
        rs1 = s1; rs2 = s2; funct7 = f7; imm = im;
        in_valid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout: observed in_ready %b expected 1", in_ready);
        end else begin
            sb.push_back({einstr, exp_addr, eerr});
            exp_addr = exp_addr + 32'd4;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Scoreboard: compare each word as it leaves the DUT.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_underflow: observed word %h expected none", out_instr);
            end else begin
                mon_e = sb.pop_front();
                check32("sb_instr", out_instr, mon_e.instr);
                check32("sb_addr", out_addr, mon_e.addr);
                check32("sb_err", {31'b0, out_err}, {31'b0, mon_e.err});
            end
        end
    end

    initial begin
        rst_n = 1'b0; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        fmt = 3'd0; opcode = 7'd0; rd = 5'd0; funct3 = 3'd0;
        rs1 = 5'd0; rs2 = 5'd0; funct7 = 7'd0; imm = 32'd0;
        restart_w = 1'b0; in_valid_w = 1'b0; out_ready_w = 1'b1;
        exp_addr = 32'h0000_0000;

        #3;
        check32("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check32("rst_out_instr", out_instr, 32'd0);
        check32("rst_out_addr", out_addr, 32'd0);
        check32("rst_out_err", {31'b0, out_err}, 32'd0);
        check32("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check32("rst_w_out_addr", out_addr_w, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 check32("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // addi x1,x0,5 with one-cycle latency
        send(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0, w);
        check32("lat_out_valid", {31'b0, out_valid}, 32'd1);
        check32("lat_out_instr", out_instr, 32'h0050_0093);
        check32("lat_out_addr", out_addr, 32'h0000_0000);
        out_ready = 1'b1;
        @(posedge clk);
        #1 check32("drain_out_valid", {31'b0, out_valid}, 32'd0);

        restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
        exp_addr = 32'h0000_0000;

        // back-to-back stream
        send(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0, 32'h0020_81B3, 1'b0, w);
        check32("b2b_wait_r", w, 32'd0);
        send(3'd2, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8, 32'h0020_A423, 1'b0, w);
        check32("b2b_wait_s", w, 32'd0);
        send(3'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0, w);
        check32("b2b_wait_b", w, 32'd0);
        send(3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048, 32'h0010_00EF, 1'b0, w);
        check32("b2b_wait_j", w, 32'd0);
        send(3'd4, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0, w);
        send(3'd6, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0, 32'h0000_0013, CHK, w);
        send(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048,
             CHK ? 32'h0000_0013 : 32'h8000_0093, CHK, w);
        send(3'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd3,
             CHK ? 32'h0000_0013 : 32'h0000_0163, CHK, w);
        @(posedge clk);

        // backpressure: outputs frozen, then same-cycle accept on out_ready rise
        #1 out_ready = 1'b0;
        send(3'd1, 7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd7, 32'h0070_0113, 1'b0, w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check32("bp_in_ready", {31'b0, in_ready}, 32'd0);
            check32("bp_out_valid", {31'b0, out_valid}, 32'd1);
            check32("bp_out_instr", out_instr, 32'h0070_0113);
            check32("bp_out_addr", out_addr, 32'h0000_0020);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(3'd0, 7'h33, 5'd4, 3'd0, 5'd2, 5'd3, 7'd0, 32'd0, 32'h0031_0233, 1'b0, w);
        check32("bp_same_cycle_accept", w, 32'd0);

        // restart while FULL and stalled
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(3'd1, 7'h13, 5'd3, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1, 32'h0010_0193, 1'b0, w);
        dropped = sb.pop_back();
        restart = 1'b1;
        @(negedge clk);
        check32("rs_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1 restart = 1'b0;
        check32("rs_out_valid", {31'b0, out_valid}, 32'd0);
        exp_addr = 32'h0000_0000;
        out_ready = 1'b1;
        send(3'd1, 7'h13, 5'd3, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1, 32'h0010_0193, 1'b0, w);
        check32("rs_base_addr", out_addr, 32'h0000_0000);

        // address wrap on the high-base instance
        fmt = 3'd1; opcode = 7'h13; rd = 5'd1; imm = 32'd5;
        @(posedge clk);
        #1 in_valid_w = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) in_valid_w = 1'b0;
            check32("wrap_out_valid", {31'b0, out_valid_w}, 32'd1);
            check32("wrap_out_addr", out_addr_w, 32'hFFFF_FFF8 + 32'd4 * i);
        end

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL drain_timeout: observed %0d pending expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
